// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared BCD width and active-low seven-segment patterns
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is driven low
    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/key_pulse.sv
// rtl/key_pulse.sv - raw key synchroniser, debouncer and rising-edge pulse
module key_pulse #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEB_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_q;
    logic [CNT_W-1:0] cnt;

    // Synchronise the key, then accept a new level only after it has differed for DEB_CYCLES cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            deb_q <= deb;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Pulse is combinational so the counter acts on the edge right after the level is accepted
    assign pulse = deb & ~deb_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - debounced BCD up/down/load counter with multiplexed 7-seg output
module bcd_updown_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 2,
    parameter int DEB_CYCLES = 20,
    parameter int SCAN_DIV   = 1000,
    parameter int SAT_MODE   = 0,
    parameter int RESET_TOP  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_up,
    input  logic                    key_down,
    input  logic                    key_load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] count_bcd,
    output logic                    tc,
    output logic [6:0]              seg_n,
    output logic [DIGITS-1:0]       dig_n
);

    localparam int W     = BCD_W * DIGITS;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [W-1:0] RESET_VAL = (RESET_TOP != 0) ? {DIGITS{4'h9}} : {DIGITS{4'h0}};

    logic             up_p;
    logic             down_p;
    logic             load_p;
    logic [W-1:0]     inc_val;
    logic             inc_carry;
    logic [W-1:0]     dec_val;
    logic             dec_borrow;
    logic [W-1:0]     clamp_val;
    logic [DIV_W-1:0] scan_div;
    logic [IDX_W-1:0] scan_idx;

    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_up (
        .clk(clk), .reset(reset), .key(key_up), .pulse(up_p)
    );

    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_down (
        .clk(clk), .reset(reset), .key(key_down), .pulse(down_p)
    );

    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_load (
        .clk(clk), .reset(reset), .key(key_load), .pulse(load_p)
    );

    // BCD increment; a carry out of the top decade means the count was all 9s
    always_comb begin
        logic [BCD_W-1:0] nib;
        nib       = '0;
        inc_val   = count_bcd;
        inc_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count_bcd[i*BCD_W +: BCD_W];
            if (inc_carry) begin
                if (nib == 4'd9) begin
                    nib = 4'd0;
                end else begin
                    nib       = nib + 4'd1;
                    inc_carry = 1'b0;
                end
            end
            inc_val[i*BCD_W +: BCD_W] = nib;
        end
    end

    // BCD decrement; a borrow out of the top decade means the count was zero
    always_comb begin
        logic [BCD_W-1:0] nib;
        nib        = '0;
        dec_val    = count_bcd;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = count_bcd[i*BCD_W +: BCD_W];
            if (dec_borrow) begin
                if (nib == 4'd0) begin
                    nib = 4'd9;
                end else begin
                    nib        = nib - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
            dec_val[i*BCD_W +: BCD_W] = nib;
        end
    end

    // Clamp each load nibble to 9 so the count never holds an illegal digit
    always_comb begin
        clamp_val = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[i*BCD_W +: BCD_W] > 4'd9) begin
                clamp_val[i*BCD_W +: BCD_W] = 4'd9;
            end
        end
    end

    // Count register with load > (up and down cancel) > up > down priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_bcd <= RESET_VAL;
            tc        <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load_p) begin
                count_bcd <= clamp_val;
            end else if (up_p && down_p) begin
                count_bcd <= count_bcd;
            end else if (up_p) begin
                tc <= inc_carry;
                if (!(inc_carry && (SAT_MODE != 0))) begin
                    count_bcd <= inc_val;
                end
            end else if (down_p) begin
                tc <= dec_borrow;
                if (!(dec_borrow && (SAT_MODE != 0))) begin
                    count_bcd <= dec_val;
                end
            end
        end
    end

    // Display scan: hold each digit for SCAN_DIV cycles, then move to the next
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_div <= '0;
            scan_idx <= '0;
        end else if (scan_div == DIV_W'(SCAN_DIV - 1)) begin
            scan_div <= '0;
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            scan_div <= scan_div + DIV_W'(1);
        end
    end

    assign dig_n = ~(DIGITS'(1) << scan_idx);
    assign seg_n = seg_decode(count_bcd[scan_idx*BCD_W +: BCD_W]);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - scoreboard bench for bcd_updown_counter in wrap and saturate modes
module tb_bcd_updown_counter;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;
    localparam int SCAN = 3;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic       tc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic       key_load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] cnt0, cnt1;
    logic       tc0, tc1;
    logic [6:0] seg0, seg1;
    logic [1:0] dig0, dig1;

    int cyc = 0;
    int rst_cyc = 0;
    int checks = 0;
    int errors = 0;
    int mval[2];
    int disp = 99;
    logic [7:0] prev[2];
    ev_t sb[2][$];
    logic [6:0] seg_ref [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bcd_updown_counter #(.DIGITS(2), .DEB_CYCLES(DEB), .SCAN_DIV(SCAN), .SAT_MODE(0), .RESET_TOP(1)) dut_wrap (
        .clk(clk), .reset(reset), .key_up(key_up), .key_down(key_down), .key_load(key_load),
        .load_val(load_val), .count_bcd(cnt0), .tc(tc0), .seg_n(seg0), .dig_n(dig0)
    );

    bcd_updown_counter #(.DIGITS(2), .DEB_CYCLES(DEB), .SCAN_DIV(SCAN), .SAT_MODE(1), .RESET_TOP(1)) dut_sat (
        .clk(clk), .reset(reset), .key_up(key_up), .key_down(key_down), .key_load(key_load),
        .load_val(load_val), .count_bcd(cnt1), .tc(tc1), .seg_n(seg1), .dig_n(dig1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: counts are plain integers 0..99, wrap or hold at the ends
    task automatic model_act(input bit u, input bit d, input bit l, input logic [7:0] lv, input int at);
        int nv;
        int d0;
        int d1;
        bit t;
        for (int k = 0; k < 2; k++) begin
            nv = mval[k];
            t  = 1'b0;
            if (l) begin
                d1 = (int'(lv[7:4]) > 9) ? 9 : int'(lv[7:4]);
                d0 = (int'(lv[3:0]) > 9) ? 9 : int'(lv[3:0]);
                nv = d1 * 10 + d0;
            end else if (u && d) begin
                nv = mval[k];
            end else if (u) begin
                if (nv == 99) begin
                    t = 1'b1;
                    if (k == 0) nv = 0;
                end else begin
                    nv = nv + 1;
                end
            end else if (d) begin
                if (nv == 0) begin
                    t = 1'b1;
                    if (k == 0) nv = 99;
                end else begin
                    nv = nv - 1;
                end
            end
            if (nv != mval[k] || t) sb[k].push_back('{at, to_bcd(nv), t});
            mval[k] = nv;
        end
    endtask

    // Monitor: any visible change of count or tc pops one expected event
    always @(negedge clk) begin
        logic [7:0] c;
        logic       t;
        ev_t        e;
        int         idx;
        for (int k = 0; k < 2; k++) begin
            c = (k == 0) ? cnt0 : cnt1;
            t = (k == 0) ? tc0 : tc1;
            if (reset) begin
                if (c !== prev[k] || t !== 1'b0) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event dut%0d: count %h tc %b at cycle %0d, no event expected", k, c, t, cyc);
                    end else begin
                        e = sb[k].pop_front();
                        check($sformatf("event_cycle_dut%0d", k), cyc, e.cyc);
                        check($sformatf("count_dut%0d", k), c, e.cnt);
                        check($sformatf("tc_dut%0d", k), t, e.tc);
                        if (k == 0) disp = int'(e.cnt[7:4]) * 10 + int'(e.cnt[3:0]);
                    end
                end else if (sb[k].size() != 0 && sb[k][0].cyc < cyc) begin
                    e = sb[k].pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_event dut%0d: count stayed %h, expected %h tc %b at cycle %0d", k, c, e.cnt, e.tc, e.cyc);
                end
            end
            prev[k] = c;
        end
        if (reset) begin
            idx = ((cyc - rst_cyc) / SCAN) % 2;
            check("scan_dig_n", dig0, (idx == 1) ? 2'b01 : 2'b10);
            check("scan_seg_n", seg0, seg_ref[(idx == 1) ? disp / 10 : disp % 10]);
        end
    end

    task automatic press(input bit u, input bit d, input bit l, input logic [7:0] lv, input int hold);
        @(negedge clk);
        load_val = lv;
        key_up   = u;
        key_down = d;
        key_load = l;
        model_act(u, d, l, lv, cyc + LAT);
        repeat (hold) @(negedge clk);
        key_up   = 1'b0;
        key_down = 1'b0;
        key_load = 1'b0;
        repeat (LAT + 4) @(negedge clk);
    endtask

    task automatic bounce(input int which, input int pulses);
        for (int i = 0; i < pulses; i++) begin
            @(negedge clk);
            key_up   = (which == 0);
            key_down = (which == 1);
            key_load = (which == 2);
            repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
            key_up   = 1'b0;
            key_down = 1'b0;
            key_load = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (LAT + 4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] lv;
        int         r;
        mval[0] = 99;
        mval[1] = 99;
        prev[0] = 8'h99;
        prev[1] = 8'h99;

        repeat (3) @(negedge clk);
        check("reset_count_wrap", cnt0, 8'h99);
        check("reset_count_sat", cnt1, 8'h99);
        check("reset_tc", tc0, 1'b0);
        check("reset_dig_n", dig0, 2'b10);
        check("reset_seg_n", seg0, 7'b0010000);
        rst_cyc = cyc;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        check("scan_after_3", dig0, 2'b01);

        press(1'b0, 1'b1, 1'b0, 8'h00, 30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            key_up = 1'b1;
            repeat (2) @(negedge clk);
            key_up = 1'b0;
            repeat (1) @(negedge clk);
        end
        repeat (LAT + 4) @(negedge clk);
        press(1'b0, 1'b0, 1'b1, 8'h00, LAT);
        press(1'b0, 1'b1, 1'b0, 8'h00, LAT);
        press(1'b0, 1'b0, 1'b1, 8'h09, LAT);
        press(1'b1, 1'b0, 1'b0, 8'h09, LAT);
        press(1'b1, 1'b1, 1'b0, 8'h09, LAT);
        press(1'b0, 1'b0, 1'b1, 8'h3C, LAT);
        press(1'b1, 1'b0, 1'b1, 8'h3C, LAT);
        press(1'b0, 1'b0, 1'b1, 8'h99, LAT);
        press(1'b1, 1'b0, 1'b0, 8'h99, LAT);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 6);
            case ($urandom_range(0, 3))
                0:       lv = 8'h00;
                1:       lv = 8'h99;
                2:       lv = 8'h09;
                default: lv = 8'($urandom);
            endcase
            case (r)
                0: press(1'b1, 1'b0, 1'b0, lv, $urandom_range(LAT, LAT + 10));
                1: press(1'b0, 1'b1, 1'b0, lv, $urandom_range(LAT, LAT + 10));
                2: press(1'b0, 1'b0, 1'b1, lv, $urandom_range(LAT, LAT + 10));
                3: press(1'b1, 1'b1, 1'b0, lv, $urandom_range(LAT, LAT + 10));
                4: press(1'b1, 1'b0, 1'b1, lv, $urandom_range(LAT, LAT + 10));
                5: press(1'b0, 1'b1, 1'b1, lv, $urandom_range(LAT, LAT + 10));
                default: bounce($urandom_range(0, 2), $urandom_range(2, 6));
            endcase
        end

        @(negedge clk);
        key_up = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_count_wrap", cnt0, 8'h99);
        check("midreset_count_sat", cnt1, 8'h99);
        check("midreset_tc", tc1, 1'b0);
        mval[0] = 99;
        mval[1] = 99;
        disp    = 99;
        repeat (2) @(negedge clk);
        rst_cyc = cyc;
        reset   = 1'b1;
        model_act(1'b1, 1'b0, 1'b0, load_val, cyc + LAT);
        repeat (30) @(negedge clk);
        key_up = 1'b0;
        repeat (LAT + 4) @(negedge clk);

        check("scoreboard_empty_wrap", sb[0].size(), 0);
        check("scoreboard_empty_sat", sb[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
